// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register family:
// operation codes and burst FSM states.
package shiftreg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_BURST = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SHIFTING = 1'b1
  } state_t;

endpackage

// File: rtl/shiftreg_bit_counter.sv
// Bit counter for serializers: synchronous clear, increment, and a
// terminal-count flag raised when the count reaches WIDTH-1.
module shiftreg_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/param_universal_shiftregister.sv
// WIDTH-bit universal shift register with single-cycle shift/rotate/load
// modes and a ready/valid burst serializer.
module param_universal_shiftregister
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              ser_in_left,
  input  logic              ser_in_right,
  input  logic              start,
  input  logic              burst_msb_first,
  input  logic              ser_ready,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic             r_order, w_order_next;
  logic             r_done, w_done_next;
  logic             w_cnt_clr, w_cnt_inc, w_cnt_tc;

  shiftreg_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_tc   (w_cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_order <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_order <= w_order_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_order_next = r_order;
    w_done_next  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;

    if (sync_reset) begin
      w_state_next = ST_IDLE;
      w_q_next     = '0;
      w_order_next = 1'b0;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        ST_SHIFTING: begin
          // Shift toward the emitted end so the next bit is always at q[0] or q[MSB].
          if (ser_ready) begin
            w_q_next  = r_order ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
            w_cnt_inc = 1'b1;
            if (w_cnt_tc) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
              w_cnt_clr    = 1'b1;
            end
          end
        end
        default: begin
          if (mode == MODE_BURST && start) begin
            w_state_next = ST_SHIFTING;
            w_q_next     = load_data;
            w_order_next = burst_msb_first;
            w_cnt_clr    = 1'b1;
          end else if (en) begin
            case (mode)
              MODE_SHR:  w_q_next = {ser_in_left, r_q[WIDTH-1:1]};
              MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], ser_in_right};
              MODE_LOAD: w_q_next = load_data;
              MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
              MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
              MODE_ASR:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
              default:   ;
            endcase
          end
        end
      endcase
    end
  end

  assign q         = r_q;
  assign busy      = (r_state == ST_SHIFTING);
  assign ser_valid = busy;
  assign ser_out   = busy ? (r_order ? r_q[WIDTH-1] : r_q[0]) : 1'b0;
  assign done      = r_done;

endmodule

// File: tb/tb_param_universal_shiftregister.sv
// Directed bench: table of single-cycle mode vectors plus hand-written
// burst, stall, back-to-back and abort sequences.
module tb_param_universal_shiftregister;
  import shiftreg_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       sync_reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] load_data;
  logic       ser_in_left;
  logic       ser_in_right;
  logic       start;
  logic       burst_msb_first;
  logic       ser_ready;
  logic [7:0] q;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  param_universal_shiftregister #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_reset     (sync_reset),
    .en             (en),
    .mode           (mode),
    .load_data      (load_data),
    .ser_in_left    (ser_in_left),
    .ser_in_right   (ser_in_right),
    .start          (start),
    .burst_msb_first(burst_msb_first),
    .ser_ready      (ser_ready),
    .q              (q),
    .ser_out        (ser_out),
    .ser_valid      (ser_valid),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] pre;
    logic [2:0] mode;
    logic       en;
    logic       sil;
    logic       sir;
    logic [7:0] op_data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic expbit(input logic [7:0] d, input logic msb, input int k);
    logic [7:0] v;
    v = d;
    return msb ? v[7-k] : v[k];
  endfunction

  task automatic start_burst(input logic [7:0] d, input logic msb);
    mode            = MODE_BURST;
    start           = 1'b1;
    en              = 1'b0;
    load_data       = d;
    burst_msb_first = msb;
    tick();
    start           = 1'b0;
    mode            = MODE_HOLD;
    burst_msb_first = ~msb;
    load_data       = 8'h00;
  endtask

  // Called in the first cycle after the start edge; returns in the done cycle.
  task automatic stream(input logic [7:0] d, input logic msb, input logic stall, input logic junk);
    int   k;
    int   cyc;
    logic rdy;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      chk("burst_busy", busy, 1);
      chk("burst_valid", ser_valid, 1);
      chk("burst_done_early", done, 0);
      chk("burst_ser_out", ser_out, expbit(d, msb, k));
      rdy = !stall || cyc[0];
      $display("[TB] burst %0h bit %0d ser_out=%0b ready=%0b", d, k, ser_out, rdy);
      ser_ready = rdy;
      if (junk) begin
        start     = 1'b1;
        en        = 1'b1;
        mode      = cyc[0] ? MODE_LOAD : MODE_BURST;
        load_data = 8'hFF;
      end
      tick();
      if (rdy) k++;
      cyc++;
    end
    if (k != 8) chk("burst_timeout", k, 8);
    start     = 1'b0;
    en        = 1'b0;
    mode      = MODE_HOLD;
    ser_ready = 1'b0;
    load_data = 8'h00;
  endtask

  task automatic chk_done_cycle(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_q_zero"}, q, 0);
    chk({tag, "_valid_low"}, ser_valid, 0);
    chk({tag, "_ser_out_low"}, ser_out, 0);
  endtask

  initial begin
    vecs[0]  = '{8'hA5, MODE_ROR,   1'b1, 1'b0, 1'b0, 8'h00, 8'hD2};
    vecs[1]  = '{8'hA5, MODE_ROL,   1'b1, 1'b0, 1'b0, 8'h00, 8'h4B};
    vecs[2]  = '{8'h80, MODE_ASR,   1'b1, 1'b0, 1'b0, 8'h00, 8'hC0};
    vecs[3]  = '{8'h01, MODE_SHR,   1'b1, 1'b1, 1'b0, 8'h00, 8'h80};
    vecs[4]  = '{8'h80, MODE_SHL,   1'b1, 1'b0, 1'b1, 8'h00, 8'h01};
    vecs[5]  = '{8'h5A, MODE_SHR,   1'b0, 1'b1, 1'b1, 8'h00, 8'h5A};
    vecs[6]  = '{8'h5A, MODE_LOAD,  1'b0, 1'b0, 1'b0, 8'hFF, 8'h5A};
    vecs[7]  = '{8'h3C, MODE_HOLD,  1'b1, 1'b1, 1'b1, 8'hFF, 8'h3C};
    vecs[8]  = '{8'h81, MODE_SHR,   1'b1, 1'b0, 1'b1, 8'h00, 8'h40};
    vecs[9]  = '{8'h81, MODE_SHL,   1'b1, 1'b1, 1'b0, 8'h00, 8'h02};
    vecs[10] = '{8'h81, MODE_ASR,   1'b1, 1'b0, 1'b0, 8'h00, 8'hC0};
    vecs[11] = '{8'h00, MODE_LOAD,  1'b1, 1'b0, 1'b0, 8'h77, 8'h77};
    vecs[12] = '{8'h5A, MODE_BURST, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h5A};

    reset_n = 1'b0; sync_reset = 1'b0; en = 1'b0; mode = MODE_HOLD;
    load_data = 8'h00; ser_in_left = 1'b0; ser_in_right = 1'b0;
    start = 1'b0; burst_msb_first = 1'b0; ser_ready = 1'b0;
    #12 reset_n = 1'b1;
    tick();

    // Asynchronous reset with a non-zero register
    mode = MODE_LOAD; en = 1'b1; load_data = 8'hFF;
    tick();
    en = 1'b0; mode = MODE_HOLD;
    chk("preload_ff", q, 8'hFF);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_valid", ser_valid, 0);
    $display("[TB] async reset q=%0h busy=%0b done=%0b", q, busy, done);
    #2 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      mode = MODE_LOAD; en = 1'b1; load_data = vecs[i].pre;
      tick();
      mode = vecs[i].mode; en = vecs[i].en;
      ser_in_left = vecs[i].sil; ser_in_right = vecs[i].sir;
      load_data = vecs[i].op_data;
      tick();
      chk($sformatf("vec%0d_q", i), q, vecs[i].exp);
      $display("[TB] vec %0d pre=%0h mode=%0d en=%0b q=%0h exp=%0h",
               i, vecs[i].pre, vecs[i].mode, vecs[i].en, q, vecs[i].exp);
      en = 1'b0; mode = MODE_HOLD; ser_in_left = 1'b0; ser_in_right = 1'b0;
    end

    // LSB-first burst, then a back-to-back burst started in the done cycle
    start_burst(8'hA5, 1'b0);
    stream(8'hA5, 1'b0, 1'b0, 1'b0);
    chk_done_cycle("lsb");
    start_burst(8'h3C, 1'b0);
    chk("b2b_done_one_cycle", done, 0);
    stream(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_done_cycle("b2b");
    tick();
    chk("b2b_done_pulse_end", done, 0);

    // MSB-first with alternate stalls and ignored start/LOAD during the burst
    start_burst(8'hA5, 1'b1);
    stream(8'hA5, 1'b1, 1'b1, 1'b1);
    chk_done_cycle("msb");
    tick();
    chk("msb_done_pulse_end", done, 0);
    chk("msb_idle_after", busy, 0);

    // Abort with sync_reset after three accepted bits
    start_burst(8'hC3, 1'b0);
    ser_ready = 1'b1;
    repeat (3) tick();
    chk("abort_sync_bit3", ser_out, 0);
    sync_reset = 1'b1;
    ser_ready = 1'b0;
    tick();
    sync_reset = 1'b0;
    chk("abort_sync_busy", busy, 0);
    chk("abort_sync_q", q, 0);
    chk("abort_sync_valid", ser_valid, 0);
    chk("abort_sync_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      ser_ready = 1'b1;
      tick();
      chk("abort_sync_no_done", done, 0);
    end
    ser_ready = 1'b0;
    $display("[TB] sync abort q=%0h busy=%0b", q, busy);

    // Abort with reset_n after three accepted bits
    start_burst(8'hC3, 1'b0);
    ser_ready = 1'b1;
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("abort_async_busy", busy, 0);
    chk("abort_async_q", q, 0);
    chk("abort_async_valid", ser_valid, 0);
    chk("abort_async_done", done, 0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_async_no_done", done, 0);
      chk("abort_async_idle", busy, 0);
    end
    ser_ready = 1'b0;
    $display("[TB] async abort q=%0h busy=%0b", q, busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
